// File: rtl/sensor_phase_seq359.sv
// Command sequencer for the sensor phase controller: CPU FIFO, per-frame slot and optional
// line-paced phase sweep (SENSOR_PHASE_SEQ_SWEEP_EN) arbitrated onto a single wcmd/cmd port.
//
// state   | meaning
// S_IDLE  | no command in flight, arbitrate frame slot > CPU FIFO > sweep credit
// S_ISSUE | one-cycle wcmd strobe, granted request consumed
// S_WAIT  | waiting for dcm_done (first cycle ignored) or timeout
// S_GAP   | SKIP_CYCLES idle cycles before the next arbitration
module sensor_phase_seq359 #(
    parameter int SKIP_CYCLES = 3,
    parameter int TIMEOUT     = 1023,
    parameter int FIFO_LOG2   = 2
) (
    input  logic       cclk,
    input  logic       nrst,
    input  logic       cpu_wr,
    input  logic [5:0] cpu_cmd,
    input  logic       frame_end,
    input  logic [5:0] frame_cmd,
    input  logic       line_start,
    input  logic       sweep_start,
    input  logic       sweep_dir,
    input  logic [7:0] sweep_steps,
    input  logic       clr_status,
    input  logic       dcm_done,
    output logic       wcmd,
    output logic [5:0] cmd,
    output logic       busy,
    output logic       sweep_active,
    output logic       sweep_done,
    output logic       cpu_ovf,
    output logic       err_timeout
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int PW    = FIFO_LOG2;
    localparam int CW    = FIFO_LOG2 + 1;
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int SW    = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;
    typedef enum logic [1:0] {G_FRAME, G_CPU, G_SWEEP} grant_t;

    state_t          state_q, state_d;
    grant_t          grant_q, grant_d;
    logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            first_q, first_d;
    logic [SW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            slot_pend_q, slot_pend_d;
    logic [5:0]      slot_cmd_q, slot_cmd_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d, tmo_q, tmo_d;
    logic [5:0]      mem_q [DEPTH];

    logic            push, pop, take_frame, take_sweep, end_wait, gap_end, tmo_set, full;
    logic            sweep_req;
    logic [5:0]      sweep_code;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        wait_cnt_d  = wait_cnt_q;
        first_d     = first_q;
        gap_cnt_d   = gap_cnt_q;
        slot_pend_d = slot_pend_q;
        slot_cmd_d  = slot_cmd_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        tmo_d       = tmo_q;
        wcmd        = 1'b0;
        cmd         = 6'h00;
        pop         = 1'b0;
        push        = 1'b0;
        take_frame  = 1'b0;
        take_sweep  = 1'b0;
        end_wait    = 1'b0;
        gap_end     = 1'b0;
        tmo_set     = 1'b0;
        full        = (count_q == CW'(DEPTH));

        case (state_q)
            S_IDLE: begin
                if (slot_pend_q || (count_q != '0) || sweep_req) begin
                    state_d = S_ISSUE;
                    if (slot_pend_q)         grant_d = G_FRAME;
                    else if (count_q != '0)  grant_d = G_CPU;
                    else                     grant_d = G_SWEEP;
                end
            end
            S_ISSUE: begin
                wcmd = 1'b1;
                case (grant_q)
                    G_FRAME: begin cmd = slot_cmd_q;      take_frame = 1'b1; end
                    G_CPU:   begin cmd = mem_q[rd_ptr_q]; pop        = 1'b1; end
                    default: begin cmd = sweep_code;      take_sweep = 1'b1; end
                endcase
                state_d    = S_WAIT;
                wait_cnt_d = TW'(TIMEOUT - 1);
                first_d    = 1'b1;
            end
            S_WAIT: begin
                first_d = 1'b0;
                if (!first_q && dcm_done) begin
                    end_wait = 1'b1;
                end else if (wait_cnt_q == '0) begin
                    end_wait = 1'b1;
                    tmo_set  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - TW'(1);
                end
                if (end_wait) begin
                    if (SKIP_CYCLES == 0) begin
                        state_d = S_IDLE;
                        gap_end = 1'b1;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = SW'(SKIP_CYCLES - 1);
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = S_IDLE;
                    gap_end = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - SW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new frame_end in the consume cycle re-arms the slot with the newer command.
        if (take_frame) slot_pend_d = 1'b0;
        if (frame_end) begin
            slot_pend_d = 1'b1;
            slot_cmd_d  = frame_cmd;
        end

        push = cpu_wr && (!full || pop);
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);

        if (clr_status) begin
            ovf_d = 1'b0;
            tmo_d = 1'b0;
        end
        if (cpu_wr && !push) ovf_d = 1'b1;
        if (tmo_set)         tmo_d = 1'b1;
    end

    always_ff @(posedge cclk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            grant_q     <= G_FRAME;
            wait_cnt_q  <= '0;
            first_q     <= 1'b0;
            gap_cnt_q   <= '0;
            slot_pend_q <= 1'b0;
            slot_cmd_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            wait_cnt_q  <= wait_cnt_d;
            first_q     <= first_d;
            gap_cnt_q   <= gap_cnt_d;
            slot_pend_q <= slot_pend_d;
            slot_cmd_q  <= slot_cmd_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge cclk) begin
        if (push) mem_q[wr_ptr_q] <= cpu_cmd;
    end

`ifdef SENSOR_PHASE_SEQ_SWEEP_EN
    logic       sw_active_q, sw_active_d, sw_dir_q, sw_dir_d;
    logic       credit_q, credit_d, sw_done_q, sw_done_d;
    logic [7:0] sw_rem_q, sw_rem_d;

    always_comb begin
        sw_active_d = sw_active_q;
        sw_dir_d    = sw_dir_q;
        credit_d    = credit_q;
        sw_rem_d    = sw_rem_q;
        sw_done_d   = 1'b0;
        if (take_sweep) begin
            credit_d = 1'b0;
            sw_rem_d = sw_rem_q - 8'd1;
        end
        if (line_start && sw_active_q && (sw_rem_d != 8'd0)) credit_d = 1'b1;
        if (gap_end && sw_active_q && (sw_rem_q == 8'd0)) begin
            sw_active_d = 1'b0;
            sw_done_d   = 1'b1;
            credit_d    = 1'b0;
        end
        if (sweep_start && !sw_active_q) begin
            if (sweep_steps == 8'd0) begin
                sw_done_d = 1'b1;
            end else begin
                sw_active_d = 1'b1;
                sw_dir_d    = sweep_dir;
                sw_rem_d    = sweep_steps;
            end
        end
    end

    always_ff @(posedge cclk or negedge nrst) begin
        if (!nrst) begin
            sw_active_q <= 1'b0;
            sw_dir_q    <= 1'b0;
            credit_q    <= 1'b0;
            sw_rem_q    <= '0;
            sw_done_q   <= 1'b0;
        end else begin
            sw_active_q <= sw_active_d;
            sw_dir_q    <= sw_dir_d;
            credit_q    <= credit_d;
            sw_rem_q    <= sw_rem_d;
            sw_done_q   <= sw_done_d;
        end
    end

    assign sweep_req    = credit_q && (sw_rem_q != 8'd0);
    assign sweep_code   = sw_dir_q ? 6'h02 : 6'h01;
    assign sweep_active = sw_active_q;
    assign sweep_done   = sw_done_q;
`else
    logic unused_sweep;
    assign unused_sweep = ^{sweep_start, sweep_dir, sweep_steps, line_start, take_sweep, gap_end};
    assign sweep_req    = 1'b0;
    assign sweep_code   = 6'h00;
    assign sweep_active = 1'b0;
    assign sweep_done   = 1'b0;
`endif

    assign busy        = (state_q != S_IDLE) || (count_q != '0) || slot_pend_q || sweep_req;
    assign cpu_ovf     = ovf_q;
    assign err_timeout = tmo_q;

endmodule

// File: tb/tb_sensor_phase_seq359.sv
// Directed bench for sensor_phase_seq359 (default parameters, sweep checks follow the build macro).
module tb_sensor_phase_seq359;
    localparam int SKIP = 3;
    localparam int TMO  = 1023;

    logic       cclk = 1'b0, nrst = 1'b0;
    logic       cpu_wr = 0, frame_end = 0, line_start = 0, sweep_start = 0, sweep_dir = 0;
    logic       clr_status = 0, dcm_done = 0;
    logic [5:0] cpu_cmd = 0, frame_cmd = 0;
    logic [7:0] sweep_steps = 0;
    logic       wcmd, busy, sweep_active, sweep_done, cpu_ovf, err_timeout;
    logic [5:0] cmd;

    sensor_phase_seq359 #(.SKIP_CYCLES(SKIP), .TIMEOUT(TMO), .FIFO_LOG2(2)) dut (
        .cclk(cclk), .nrst(nrst), .cpu_wr(cpu_wr), .cpu_cmd(cpu_cmd),
        .frame_end(frame_end), .frame_cmd(frame_cmd), .line_start(line_start),
        .sweep_start(sweep_start), .sweep_dir(sweep_dir), .sweep_steps(sweep_steps),
        .clr_status(clr_status), .dcm_done(dcm_done), .wcmd(wcmd), .cmd(cmd), .busy(busy),
        .sweep_active(sweep_active), .sweep_done(sweep_done), .cpu_ovf(cpu_ovf),
        .err_timeout(err_timeout)
    );

    always #5 cclk = ~cclk;

    int         cyc = 0;
    logic [5:0] cmd_log[$];
    int         cyc_log[$];
    int         done_pulses = 0;
    int         checks = 0, failures = 0;

    always @(posedge cclk) cyc <= cyc + 1;

    always @(posedge cclk) begin
        #1;
        if (wcmd) begin
            cmd_log.push_back(cmd);
            cyc_log.push_back(cyc);
        end
        if (sweep_done) done_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge cclk);
    endtask

    task automatic wait_wcmd(input int idx, input string tag);
        int k = 0;
        while (cmd_log.size() <= idx && k < 200) begin tick(); k++; end
        chk(tag, 32'(cmd_log.size() > idx), 1);
    endtask

    task automatic pulse_done();
        tick(3);
        dcm_done = 1; tick(); dcm_done = 0;
    endtask

    task automatic serve(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            wait_wcmd(idx + i, "serve_wait");
            pulse_done();
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 100) begin tick(); k++; end
        chk(tag, 32'(busy), 0);
    endtask

    task automatic cpu_write(input logic [5:0] c);
        cpu_cmd = c; cpu_wr = 1; tick(); cpu_wr = 0;
    endtask

    int base, w, d;

    initial begin
        // reset
        tick(2);
        chk("rst_wcmd", 32'(wcmd), 0);
        chk("rst_cmd", 32'(cmd), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", 32'({sweep_active, sweep_done, cpu_ovf, err_timeout}), 0);
        nrst = 1; tick(2);

        // single command 0x3f: 2-cycle latency, one strobe, gap after dcm_done
        cpu_cmd = 6'h3f; cpu_wr = 1; tick(); cpu_wr = 0;
        chk("lat1_wcmd", 32'(wcmd), 0);
        chk("lat1_busy", 32'(busy), 1);
        tick();
        chk("lat2_wcmd", 32'(wcmd), 1);
        chk("lat2_cmd", 32'(cmd), 32'h3f);
        w = cyc;
        tick();
        chk("single_pulse", 32'(wcmd), 0);
        chk("cmd_zero_idle", 32'(cmd), 0);
        cpu_write(6'h15);
        tick(2);
        d = cyc; dcm_done = 1; tick(); dcm_done = 0;
        wait_wcmd(1, "second_cmd");
        chk("second_val", 32'(cmd_log[1]), 32'h15);
        // one edge into GAP, SKIP edges in GAP, one edge into ISSUE
        chk("gap_spacing", 32'(cyc_log[1] - d), 32'(SKIP + 2));
        pulse_done();
        wait_idle("t1_idle");

        // FIFO overflow: 5 writes while a command is outstanding
        base = cmd_log.size();
        cpu_write(6'h30);
        wait_wcmd(base, "ovf_prime");
        for (int i = 1; i <= 5; i++) begin
            cpu_cmd = 6'(i); cpu_wr = 1; tick();
        end
        cpu_wr = 0;
        chk("ovf_set", 32'(cpu_ovf), 1);
        pulse_done();
        serve(base + 1, 4);
        wait_idle("ovf_idle");
        chk("ovf_count", 32'(cmd_log.size() - base), 5);
        for (int i = 1; i <= 4; i++) chk("ovf_order", 32'(cmd_log[base + i]), 32'(i));
        clr_status = 1; tick(); clr_status = 0;
        chk("ovf_clr", 32'(cpu_ovf), 0);

        // frame slot beats CPU FIFO
        base = cmd_log.size();
        frame_cmd = 6'h0b; frame_end = 1; cpu_cmd = 6'h20; cpu_wr = 1; tick();
        frame_end = 0; cpu_wr = 0;
        serve(base, 2);
        wait_idle("prio_idle");
        chk("prio_first", 32'(cmd_log[base]), 32'h0b);
        chk("prio_second", 32'(cmd_log[base + 1]), 32'h20);

        // frame slot overwrite while pending
        base = cmd_log.size();
        cpu_write(6'h05);
        wait_wcmd(base, "ovr_prime");
        tick();
        frame_cmd = 6'h11; frame_end = 1; tick();
        frame_cmd = 6'h12; tick(); frame_end = 0;
        pulse_done();
        serve(base + 1, 1);
        wait_idle("ovr_idle");
        chk("ovr_count", 32'(cmd_log.size() - base), 2);
        chk("ovr_val", 32'(cmd_log[base + 1]), 32'h12);

`ifdef SENSOR_PHASE_SEQ_SWEEP_EN
        base = cmd_log.size();
        sweep_dir = 0; sweep_steps = 8'd3; sweep_start = 1; tick(); sweep_start = 0;
        chk("sw_active", 32'(sweep_active), 1);
        for (int i = 0; i < 3; i++) begin
            line_start = 1; tick(); line_start = 0;
            wait_wcmd(base + i, "sw_wait");
            chk("sw_cmd", 32'(cmd_log[base + i]), 32'h01);
            pulse_done();
        end
        for (int k = 0; k < 50 && done_pulses == 0; k++) tick();
        tick(2);
        chk("sw_done_cnt", 32'(done_pulses), 1);
        chk("sw_inactive", 32'(sweep_active), 0);
        chk("sw_total", 32'(cmd_log.size() - base), 3);
        sweep_steps = 8'd0; sweep_start = 1; tick(); sweep_start = 0; tick(2);
        chk("sw_zero_done", 32'(done_pulses), 2);
        chk("sw_zero_active", 32'(sweep_active), 0);
`else
        base = cmd_log.size();
        sweep_steps = 8'd3; sweep_start = 1; tick(); sweep_start = 0;
        for (int i = 0; i < 3; i++) begin
            line_start = 1; tick(); line_start = 0; tick(2);
        end
        chk("nosw_active", 32'(sweep_active), 0);
        chk("nosw_done", 32'(done_pulses), 0);
        chk("nosw_busy", 32'(busy), 0);
        chk("nosw_cmds", 32'(cmd_log.size() - base), 0);
`endif

        // dcm_done never arrives
        base = cmd_log.size();
        cpu_write(6'h2a);
        wait_wcmd(base, "tmo_issue");
        w = cyc_log[base];
        while (cyc < w + TMO) tick();
        chk("tmo_early", 32'(err_timeout), 0);
        chk("tmo_busy", 32'(busy), 1);
        tick();
        chk("tmo_set", 32'(err_timeout), 1);
        wait_idle("tmo_idle");
        chk("tmo_no_retry", 32'(cmd_log.size() - base), 1);
        clr_status = 1; tick(); clr_status = 0;
        chk("tmo_clr", 32'(err_timeout), 0);

        // reset during WAIT with requests pending
        base = cmd_log.size();
        cpu_write(6'h07);
        wait_wcmd(base, "rstw_issue");
        tick();
        frame_cmd = 6'h0c; frame_end = 1; tick(); frame_end = 0;
        cpu_write(6'h08);
        #2 nrst = 0;
        #1;
        chk("rstw_wcmd", 32'(wcmd), 0);
        chk("rstw_cmd", 32'(cmd), 0);
        chk("rstw_busy", 32'(busy), 0);
        chk("rstw_flags", 32'({sweep_active, sweep_done, cpu_ovf, err_timeout}), 0);
        tick(2); nrst = 1;
        tick(20);
        chk("rstw_quiet", 32'(cmd_log.size() - base), 1);
        chk("rstw_idle", 32'(busy), 0);
        cpu_write(6'h09);
        serve(base + 1, 1);
        wait_idle("rstw_end");
        chk("rstw_new", 32'(cmd_log[base + 1]), 32'h09);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sensor_phase_seq359.md
SENSOR_PHASE_SEQ359 -- requirements
Module: sensor_phase_seq359

Interface
REQ-001 SHALL have parameters: SKIP_CYCLES, default 3, idle cclk cycles after each completed command; TIMEOUT, default 1023, max cclk cycles waiting for dcm_done; FIFO_LOG2, default 2, log2 of CPU command FIFO depth.
REQ-002 SHALL have ports (clock and reset first):
- cclk  in  1  command clock; all logic on posedge
- nrst  in  1  asynchronous active-low reset
- cpu_wr  in  1  CPU command write strobe
- cpu_cmd  in  6  CPU command code
- frame_end  in  1  one-cycle pulse at sensor VACT fall
- frame_cmd  in  6  command issued once per frame_end
- line_start  in  1  one-cycle pulse at sensor HACT rise
- sweep_start  in  1  start phase sweep pulse
- sweep_dir  in  1  0 = increase (cmd 0x01), 1 = decrease (cmd 0x02)
- sweep_steps  in  8  number of sweep steps
- clr_status  in  1  clears sticky flags
- dcm_done  in  1  level, phase controller command complete
- wcmd  out  1  command write strobe to phase controller
- cmd  out  6  command code to phase controller
- busy  out  1  sequencer not IDLE or any request pending
- sweep_active  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse at sweep completion
- cpu_ovf  out  1  sticky, CPU write dropped
- err_timeout  out  1  sticky, dcm_done timeout

Function
REQ-003 SHALL buffer CPU commands in a 2**FIFO_LOG2-entry FIFO; cpu_wr when full drops the write and sets cpu_ovf; simultaneous write and pop when full is accepted.
REQ-004 SHALL latch frame_cmd on frame_end into a single pending slot; frame_end while pending overwrites the slot.
REQ-005 SHALL, on sweep_start while not sweep_active, latch sweep_dir and sweep_steps and set sweep_active; sweep_start while sweep_active is ignored.
REQ-006 SHALL, with sweep_steps = 0, not set sweep_active and pulse sweep_done the next cycle.
REQ-007 SHALL accumulate one step credit per line_start while sweep_active; credit is a 1-bit flag (extra line_start while credit set is lost).
REQ-008 SHALL arbitrate in IDLE with fixed priority: frame slot > CPU FIFO > sweep credit.
REQ-009 SHALL implement states IDLE, ISSUE, WAIT, GAP: IDLE->ISSUE when any request present; ISSUE drives wcmd=1 and cmd for exactly one cycle, then WAIT; WAIT->GAP on dcm_done=1 or timeout; GAP holds SKIP_CYCLES cycles then IDLE.
REQ-010 SHALL ignore dcm_done during the first cycle of WAIT.
REQ-011 SHALL, when WAIT exceeds TIMEOUT cycles, set err_timeout and proceed to GAP.
REQ-012 SHALL hold cmd at 0 when wcmd=0.
REQ-013 SHALL consume the granted request (clear slot, pop FIFO, clear credit and decrement remaining steps) in the ISSUE cycle.
REQ-014 SHALL, when remaining steps reach 0 after the last sweep command's GAP, clear sweep_active and pulse sweep_done.
REQ-015 SHALL clear cpu_ovf and err_timeout on clr_status; a set event in the same cycle wins.
REQ-016 SHALL give total latency cpu_wr (idle, empty) -> wcmd of 2 cycles.

Reset
REQ-017 SHALL, on nrst low, asynchronously force IDLE, empty FIFO, clear frame slot, credit, sweep state and counters, and drive all outputs 0.
REQ-018 SHALL, on reset mid-command, abandon the command without further wcmd.

Configuration
REQ-019 SHALL compile the sweep engine only when SENSOR_PHASE_SEQ_SWEEP_EN is defined; without it sweep_start, sweep_dir, sweep_steps and line_start are ignored, sweep_active and sweep_done are tied 0, and arbitration covers frame slot and CPU FIFO only.

Verification
REQ-020 SHALL cover: cpu_wr cmd 0x3f, dcm_done asserted 5 cycles after wcmd -> single wcmd pulse with cmd=0x3f, next command no earlier than SKIP_CYCLES+1 cycles after dcm_done.
REQ-021 SHALL cover: 5 cpu_wr back-to-back with FIFO_LOG2=2 while busy -> 4 commands issued in order, cpu_ovf=1.
REQ-022 SHALL cover: frame_end (frame_cmd=0x0b) and cpu_wr 0x20 same cycle -> 0x0b issued before 0x20.
REQ-023 SHALL cover: sweep_start, sweep_dir=0, sweep_steps=3, three line_start pulses -> three cmd=0x01, one sweep_done pulse, sweep_active then 0.
REQ-024 SHALL cover: dcm_done held 0 -> err_timeout set after TIMEOUT cycles, sequencer returns to IDLE; clr_status clears it.
REQ-025 SHALL cover: nrst asserted during WAIT -> all outputs 0 immediately, no wcmd after release until a new request.
